// File: rtl/nidhogg_pkg.sv
// Shared types for the duel referee: FSM state encoding, player ids and a
// saturating score increment.
package nidhogg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FIGHT,
    POINT,
    DONE
  } referee_state_t;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] P1   = 2'd1;
  localparam logic [1:0] P2   = 2'd2;

  function automatic logic [1:0] sat_inc(input logic [1:0] value, input logic [1:0] limit);
    return (value >= limit) ? limit : value + 2'd1;
  endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round countdown: frame ticks are divided down to whole seconds and
// time_left counts toward zero while enabled.
module round_timer #(
  parameter int ROUND_SECONDS = 60,
  parameter int FPS           = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       enable,
  input  logic       frame_tick,
  output logic [6:0] time_left,
  output logic       expired
);

  localparam int              FW         = (FPS > 1) ? $clog2(FPS) : 1;
  localparam int              LAST_INT   = FPS - 1;
  localparam logic [FW-1:0]   LAST_FRAME = LAST_INT[FW-1:0];
  localparam logic [6:0]      RELOAD     = ROUND_SECONDS[6:0];

  logic [FW-1:0] frame_cnt;

  // load beats a coincident tick so the fresh round starts on a clean second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      time_left <= RELOAD;
    end else if (load) begin
      frame_cnt <= '0;
      time_left <= RELOAD;
    end else if (enable && frame_tick) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt <= '0;
        if (time_left != 7'd0) begin
          time_left <= time_left - 7'd1;
        end
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign expired = (time_left == 7'd0);

endmodule

// File: rtl/match_referee.sv
// Duel referee: tracks points, freeze periods and round time, and declares
// the match winner once a player reaches ROUNDS_TO_WIN.
module match_referee
  import nidhogg_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int FREEZE_FRAMES = 90,
  parameter int ROUND_SECONDS = 60,
  parameter int FPS           = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_active,
  input  logic       frame_tick,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic       win,
  output logic [1:0] winner,
  output logic [1:0] p1_score,
  output logic [1:0] p2_score,
  output logic [6:0] time_left,
  output logic       freeze,
  output logic       respawn
);

  localparam int             FCW           = (FREEZE_FRAMES > 0) ? $clog2(FREEZE_FRAMES + 1) : 1;
  localparam logic [FCW:0]   FREEZE_TARGET = FREEZE_FRAMES[FCW:0];
  localparam logic [1:0]     WIN_SCORE     = ROUNDS_TO_WIN[1:0];

  referee_state_t state;
  logic           ga_prev;
  logic [FCW-1:0] freeze_cnt;
  logic [FCW:0]   freeze_sum;
  logic           freeze_done;
  logic           ga_rise;
  logic           lone_p1;
  logic           lone_p2;
  logic           double_touch;
  logic [1:0]     p1_next;
  logic [1:0]     p2_next;
  logic           timer_expired;
  logic           enter_start;
  logic           fight_to_point;
  logic           timer_load;
  logic           timer_enable;

  assign ga_rise      = game_active & ~ga_prev;
  assign lone_p1      = p1_hit & ~p2_hit;
  assign lone_p2      = p2_hit & ~p1_hit;
  assign double_touch = p1_hit & p2_hit;
  assign p1_next      = sat_inc(p1_score, WIN_SCORE);
  assign p2_next      = sat_inc(p2_score, WIN_SCORE);
  assign freeze_sum   = {1'b0, freeze_cnt} + {{FCW{1'b0}}, frame_tick};
  assign freeze_done  = (freeze_sum >= FREEZE_TARGET);

  // The timer must reload on the same edge that enters START or POINT.
  assign enter_start    = (state == IDLE) && ga_rise;
  assign fight_to_point = (state == FIGHT) && game_active &&
                          (double_touch ||
                           (lone_p1 && (p1_next != WIN_SCORE)) ||
                           (lone_p2 && (p2_next != WIN_SCORE)) ||
                           (!p1_hit && !p2_hit && timer_expired));
  assign timer_load     = enter_start | fight_to_point;
  assign timer_enable   = (state == FIGHT);

  round_timer #(
    .ROUND_SECONDS(ROUND_SECONDS),
    .FPS          (FPS)
  ) u_round_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load),
    .enable    (timer_enable),
    .frame_tick(frame_tick),
    .time_left (time_left),
    .expired   (timer_expired)
  );

  // ga_prev resets high so a game_active already high at reset release needs a fresh edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ga_prev    <= 1'b1;
      freeze_cnt <= '0;
      p1_score   <= 2'd0;
      p2_score   <= 2'd0;
      winner     <= NONE;
      win        <= 1'b0;
      freeze     <= 1'b1;
      respawn    <= 1'b0;
    end else begin
      ga_prev <= game_active;
      respawn <= 1'b0;
      case (state)
        IDLE: begin
          freeze <= 1'b1;
          if (ga_rise) begin
            state      <= START;
            p1_score   <= 2'd0;
            p2_score   <= 2'd0;
            winner     <= NONE;
            respawn    <= 1'b1;
            freeze_cnt <= FCW'(frame_tick);
          end
        end
        START, POINT: begin
          if (!game_active) begin
            state      <= IDLE;
            freeze     <= 1'b1;
            freeze_cnt <= '0;
          end else if (freeze_done) begin
            state      <= FIGHT;
            freeze     <= 1'b0;
            freeze_cnt <= '0;
          end else if (frame_tick) begin
            freeze_cnt <= freeze_cnt + 1'b1;
          end
        end
        FIGHT: begin
          if (!game_active) begin
            state  <= IDLE;
            freeze <= 1'b1;
          end else if (lone_p1) begin
            p1_score <= p1_next;
            freeze   <= 1'b1;
            if (p1_next == WIN_SCORE) begin
              state  <= DONE;
              win    <= 1'b1;
              winner <= P1;
            end else begin
              state      <= POINT;
              respawn    <= 1'b1;
              freeze_cnt <= FCW'(frame_tick);
            end
          end else if (lone_p2) begin
            p2_score <= p2_next;
            freeze   <= 1'b1;
            if (p2_next == WIN_SCORE) begin
              state  <= DONE;
              win    <= 1'b1;
              winner <= P2;
            end else begin
              state      <= POINT;
              respawn    <= 1'b1;
              freeze_cnt <= FCW'(frame_tick);
            end
          end else if (double_touch || timer_expired) begin
            state      <= POINT;
            freeze     <= 1'b1;
            respawn    <= 1'b1;
            freeze_cnt <= FCW'(frame_tick);
          end
        end
        DONE: begin
          if (!game_active) begin
            state <= IDLE;
            win   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          freeze <= 1'b1;
          win    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_referee.sv
// Directed bench for match_referee with small parameters: a vector table for
// the main match flow plus hand-written async-reset and re-arm sequences.
module tb_match_referee;

  logic       clk;
  logic       rst_n;
  logic       game_active;
  logic       frame_tick;
  logic       p1_hit;
  logic       p2_hit;
  logic       win;
  logic [1:0] winner;
  logic [1:0] p1_score;
  logic [1:0] p2_score;
  logic [6:0] time_left;
  logic       freeze;
  logic       respawn;

  int check_count;
  int pass_count;

  typedef struct {
    string       name;
    logic        ga;
    logic        tick;
    logic        h1;
    logic        h2;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  match_referee #(
    .ROUNDS_TO_WIN(3),
    .FREEZE_FRAMES(2),
    .ROUND_SECONDS(2),
    .FPS          (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_active(game_active),
    .frame_tick (frame_tick),
    .p1_hit     (p1_hit),
    .p2_hit     (p2_hit),
    .win        (win),
    .winner     (winner),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .time_left  (time_left),
    .freeze     (freeze),
    .respawn    (respawn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pack(input logic w, input logic [1:0] wn, input logic [1:0] s1,
                                       input logic [1:0] s2, input logic [6:0] tl, input logic fz,
                                       input logic rs);
    return {w, wn, s1, s2, tl, fz, rs};
  endfunction

  function automatic string show(input logic [15:0] v);
    return $sformatf("win=%0d winner=%0d p1=%0d p2=%0d time_left=%0d freeze=%0d respawn=%0d",
                     v[15], v[14:13], v[12:11], v[10:9], v[8:2], v[1], v[0]);
  endfunction

  task automatic addVec(input string name, input logic ga, input logic tick, input logic h1,
                        input logic h2, input logic w, input logic [1:0] wn, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [6:0] tl, input logic fz, input logic rs);
    vec_t v;
    v.name = name;
    v.ga   = ga;
    v.tick = tick;
    v.h1   = h1;
    v.h2   = h2;
    v.exp  = pack(w, wn, s1, s2, tl, fz, rs);
    vecs.push_back(v);
  endtask

  // Inputs are held through one rising edge; outputs are then read 1ns later.
  task automatic applyStimulus(input logic ga, input logic tick, input logic h1, input logic h2);
    game_active = ga;
    frame_tick  = tick;
    p1_hit      = h1;
    p2_hit      = h2;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expected);
    logic [15:0] actual;
    actual = {win, winner, p1_score, p2_score, time_left, freeze, respawn};
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %s, expected %s", name, show(actual), show(expected));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_count = 0;
    pass_count  = 0;

    //     name                 ga tk h1 h2   win wn s1 s2 tl fz rs
    addVec("idle_low",          0, 0, 0, 0,   0, 0, 0, 0, 2, 1, 0);
    addVec("ga_rise",           1, 0, 0, 0,   0, 0, 0, 0, 2, 1, 1);
    addVec("start_tick1",       1, 1, 0, 0,   0, 0, 0, 0, 2, 1, 0);
    addVec("start_wait",        1, 0, 0, 0,   0, 0, 0, 0, 2, 1, 0);
    addVec("start_tick2",       1, 1, 0, 0,   0, 0, 0, 0, 2, 0, 0);
    addVec("p1_hit_1",          1, 0, 1, 0,   0, 0, 1, 0, 2, 1, 1);
    addVec("point_tick1",       1, 1, 0, 0,   0, 0, 1, 0, 2, 1, 0);
    addVec("point_tick2",       1, 1, 0, 0,   0, 0, 1, 0, 2, 0, 0);
    addVec("p2_hit_1",          1, 0, 0, 1,   0, 0, 1, 1, 2, 1, 1);
    addVec("hit_in_point",      1, 0, 1, 0,   0, 0, 1, 1, 2, 1, 0);
    addVec("point_tick1b",      1, 1, 0, 0,   0, 0, 1, 1, 2, 1, 0);
    addVec("point_tick2b",      1, 1, 0, 0,   0, 0, 1, 1, 2, 0, 0);
    addVec("p1_hit_2",          1, 0, 1, 0,   0, 0, 2, 1, 2, 1, 1);
    addVec("point_tick1c",      1, 1, 0, 0,   0, 0, 2, 1, 2, 1, 0);
    addVec("point_tick2c",      1, 1, 0, 0,   0, 0, 2, 1, 2, 0, 0);
    addVec("double_touch",      1, 0, 1, 1,   0, 0, 2, 1, 2, 1, 1);
    addVec("point_tick1d",      1, 1, 0, 0,   0, 0, 2, 1, 2, 1, 0);
    addVec("point_tick2d",      1, 1, 0, 0,   0, 0, 2, 1, 2, 0, 0);
    addVec("fight_tick1",       1, 1, 0, 0,   0, 0, 2, 1, 2, 0, 0);
    addVec("fight_tick2",       1, 1, 0, 0,   0, 0, 2, 1, 2, 0, 0);
    addVec("fight_tick3",       1, 1, 0, 0,   0, 0, 2, 1, 1, 0, 0);
    addVec("fight_tick4",       1, 1, 0, 0,   0, 0, 2, 1, 1, 0, 0);
    addVec("fight_tick5",       1, 1, 0, 0,   0, 0, 2, 1, 1, 0, 0);
    addVec("fight_tick6",       1, 1, 0, 0,   0, 0, 2, 1, 0, 0, 0);
    addVec("timeout_draw",      1, 0, 0, 0,   0, 0, 2, 1, 2, 1, 1);
    addVec("point_tick1e",      1, 1, 0, 0,   0, 0, 2, 1, 2, 1, 0);
    addVec("point_tick2e",      1, 1, 0, 0,   0, 0, 2, 1, 2, 0, 0);
    addVec("fight2_tick1",      1, 1, 0, 0,   0, 0, 2, 1, 2, 0, 0);
    addVec("fight2_tick2",      1, 1, 0, 0,   0, 0, 2, 1, 2, 0, 0);
    addVec("fight2_tick3",      1, 1, 0, 0,   0, 0, 2, 1, 1, 0, 0);
    addVec("fight2_tick4",      1, 1, 0, 0,   0, 0, 2, 1, 1, 0, 0);
    addVec("fight2_tick5",      1, 1, 0, 0,   0, 0, 2, 1, 1, 0, 0);
    addVec("fight2_tick6",      1, 1, 0, 0,   0, 0, 2, 1, 0, 0, 0);
    addVec("hit_at_timeout",    1, 0, 1, 0,   1, 1, 3, 1, 0, 1, 0);
    addVec("hit_in_done",       1, 0, 0, 1,   1, 1, 3, 1, 0, 1, 0);
    addVec("ga_fall_done",      0, 0, 0, 0,   0, 1, 3, 1, 0, 1, 0);
    addVec("idle_hold",         0, 1, 1, 0,   0, 1, 3, 1, 0, 1, 0);
    addVec("ga_rise_2",         1, 0, 0, 0,   0, 0, 0, 0, 2, 1, 1);
    addVec("start_hit_ignored", 1, 1, 1, 0,   0, 0, 0, 0, 2, 1, 0);
    addVec("start_tick2f",      1, 1, 0, 0,   0, 0, 0, 0, 2, 0, 0);
    addVec("ga_fall_fight",     0, 0, 0, 0,   0, 0, 0, 0, 2, 1, 0);
    addVec("rise_with_tick",    1, 1, 0, 0,   0, 0, 0, 0, 2, 1, 1);
    addVec("fight_after_one",   1, 1, 0, 0,   0, 0, 0, 0, 2, 0, 0);

    game_active = 1'b0;
    frame_tick  = 1'b0;
    p1_hit      = 1'b0;
    p2_hit      = 1'b0;
    rst_n       = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_values", pack(0, 0, 0, 0, 2, 1, 0));
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ga, vecs[i].tick, vecs[i].h1, vecs[i].h2);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Build p2_score=2 in FIGHT, then hit reset mid-cycle.
    applyStimulus(1, 0, 0, 1);
    checkOutput("p2_seq_1", pack(0, 0, 0, 1, 2, 1, 1));
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("p2_seq_2", pack(0, 0, 0, 2, 2, 1, 1));
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("fight_p2_two", pack(0, 0, 0, 2, 2, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", pack(0, 0, 0, 0, 2, 1, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput($sformatf("no_restart_%0d", i), pack(0, 0, 0, 0, 2, 1, 0));
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("rearm_low", pack(0, 0, 0, 0, 2, 1, 0));
    applyStimulus(1, 0, 0, 0);
    checkOutput("fresh_rise", pack(0, 0, 0, 0, 2, 1, 1));
    applyStimulus(1, 0, 0, 0);
    checkOutput("respawn_once", pack(0, 0, 0, 0, 2, 1, 0));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/match_referee.md
MATCH_REFEREE -- requirements
Module: match_referee

Interface
REQ-001 Parameter ROUNDS_TO_WIN, default 3, points needed to win a match; legal range 1..3.
REQ-002 Parameter FREEZE_FRAMES, default 90, frame ticks that players stay frozen at match start and after each point.
REQ-003 Parameter ROUND_SECONDS, default 60, per-round time limit in seconds; legal range 1..127.
REQ-004 Parameter FPS, default 60, frame ticks per second.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 game_active  input  1  high while the top-level FSM is in GAME_FOREST or GAME_CASTLE.
REQ-008 frame_tick  input  1  one-clk pulse per video frame.
REQ-009 p1_hit  input  1  one-clk pulse: player 1's sword hit player 2.
REQ-010 p2_hit  input  1  one-clk pulse: player 2's sword hit player 1.
REQ-011 win  output  1  level, high while in DONE; drives the top-level FSM win input.
REQ-012 winner  output  2  0 none, 1 P1, 2 P2.
REQ-013 p1_score  output  2  points won by player 1.
REQ-014 p2_score  output  2  points won by player 2.
REQ-015 time_left  output  7  whole seconds remaining in the current round.
REQ-016 freeze  output  1  high when player movement is inhibited.
REQ-017 respawn  output  1  one-clk pulse: return both players to their start positions.

Function
REQ-018 States: IDLE, START, FIGHT, POINT, DONE.
REQ-019 IDLE: freeze=1; scores and winner hold; a game_active rising edge clears scores/winner, loads the timer and moves to START, with respawn pulsed in that same cycle.
REQ-020 START/POINT: freeze=1; count FREEZE_FRAMES frame_ticks, then move to FIGHT; time_left reloads to ROUND_SECONDS on entry.
REQ-021 FIGHT: freeze=0; time_left decrements once every FPS frame_ticks.
REQ-022 In FIGHT, a lone p1_hit in cycle N increments p1_score at edge N+1; p2_hit is symmetric.
REQ-023 After a scored point, if the new score equals ROUNDS_TO_WIN, move to DONE, else move to POINT and pulse respawn.
REQ-024 Both hits in the same cycle (double touch): no score change; move to POINT; pulse respawn.
REQ-025 If time_left reaches 0 in FIGHT, treat it as a draw round: no score change; move to POINT; pulse respawn.
REQ-026 If a hit and the timeout occur in the same cycle, the hit takes priority.
REQ-027 Hits outside FIGHT are ignored.
REQ-028 DONE: win=1, freeze=1, winner set; when game_active falls, move to IDLE, keeping scores and winner for display.
REQ-029 game_active falling in START/FIGHT/POINT: move to IDLE on the next edge; scores and winner hold; win stays 0.
REQ-030 Scores saturate at ROUNDS_TO_WIN; no wrap-around.
REQ-031 frame_tick coincident with a state transition: consumed by the new state's counter only.

Reset
REQ-032 rst_n low: state=IDLE immediately; win=0, winner=0, scores=0, time_left=ROUND_SECONDS, freeze=1, respawn=0, all internal counters=0.
REQ-033 Reset deassertion while game_active is already high: no START until game_active has gone low then high.

Structure
REQ-034 Shared package nidhogg_pkg holds the referee state encoding and the player-id constants (NONE=0, P1=1, P2=2).
REQ-035 Sub-module round_timer holds the frame/second down-counter: load, enable, frame_tick in; time_left and expired out.
REQ-036 The referee FSM, score registers and freeze counter stay in match_referee.

Verification (ROUNDS_TO_WIN=3, FREEZE_FRAMES=2, ROUND_SECONDS=2, FPS=3)
REQ-037 game_active rise, 2 ticks -> respawn once, freeze 1 then 0 after the 2nd tick, time_left=2.
REQ-038 Three lone p1_hit pulses, each in FIGHT -> p1_score 1,2,3; after the 3rd, win=1, winner=1, freeze=1; game_active low -> IDLE, win=0, p1_score stays 3.
REQ-039 p1_hit and p2_hit in the same cycle in FIGHT -> scores unchanged, POINT entered, respawn pulse.
REQ-040 6 ticks in FIGHT with no hits -> time_left 2,1,0; POINT entered, respawn pulse, scores unchanged.
REQ-041 Hit in the timeout cycle -> point awarded; game_active low mid-FIGHT -> IDLE next edge.
REQ-042 rst_n pulsed during FIGHT with p2_score=2 -> all outputs at reset values asynchronously; no START until a fresh game_active edge.
